reorder_queue: RTL and testbench

// - Parametrised in-order-retire buffer for the out-of-order core; generalises the fixed 2-way buffer to WIDTH-way alloc/commit.
// - Sits between dispatch (allocates tags), EX->BF writeback (marks done) and commit (drains to regfile).
// - Adds branch-squash by tag: entries younger than a mispredicted branch are discarded and tail rewinds.

---
 rtl/reorder_queue.sv | 152 +++++++++++++++
 tb/tb_reorder_queue.sv | 303 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/reorder_queue.sv
// WIDTH-way in-order-retire reorder buffer with out-of-order writeback and branch squash by tag.
// Define REORDER_QUEUE_STORE_SERIAL_EN to limit retirement to one store per cycle.
module reorder_queue #(
    parameter int unsigned WIDTH     = 2,
    parameter int unsigned DEPTH     = 16,
    parameter int unsigned DEPTH_LOG = 4,
    parameter int unsigned DATA_W    = 32
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic [WIDTH-1:0]                  alloc_valid,
    input  logic [WIDTH-1:0][4:0]             alloc_rd,
    input  logic [WIDTH-1:0]                  alloc_store,
    output logic                              alloc_ready,
    output logic [WIDTH-1:0][DEPTH_LOG:0]     alloc_tag,
    input  logic [WIDTH-1:0]                  wb_valid,
    input  logic [WIDTH-1:0][DEPTH_LOG:0]     wb_tag,
    input  logic [WIDTH-1:0][DATA_W-1:0]      wb_data,
    input  logic                              flush_valid,
    input  logic [DEPTH_LOG:0]                flush_tag,
    output logic [WIDTH-1:0]                  cm_valid,
    output logic [WIDTH-1:0][4:0]             cm_rd,
    output logic [WIDTH-1:0][DATA_W-1:0]      cm_data,
    output logic [WIDTH-1:0]                  cm_store,
    output logic [WIDTH-1:0][DEPTH_LOG:0]     cm_tag,
    output logic [DEPTH_LOG:0]                count
);

    localparam int unsigned TW = DEPTH_LOG + 1;

    logic [DEPTH-1:0]        valid_q;
    logic [DEPTH-1:0]        done_q;
    logic [DEPTH-1:0]        store_q;
    logic [4:0]              rd_q   [DEPTH];
    logic [DATA_W-1:0]       data_q [DEPTH];
    logic [TW-1:0]           head_q;
    logic [TW-1:0]           tail_q;

    logic [TW-1:0]           n_alloc;
    logic [TW-1:0]           n_commit;
    logic [TW-1:0]           fdist;
    logic [DEPTH_LOG-1:0]    age_c [DEPTH];
    logic [DEPTH-1:0]        kill;
    logic [DEPTH_LOG-1:0]    cidx;
    logic                    chain;
    logic                    elig;
`ifdef REORDER_QUEUE_STORE_SERIAL_EN
    logic                    store_seen;
`endif

    // Occupancy, allocation tags and dispatch back-pressure
    always_comb begin
        count   = tail_q - head_q;
        n_alloc = '0;
        for (int i = 0; i < WIDTH; i++) begin
            alloc_tag[i] = tail_q + TW'(i);
            n_alloc      = n_alloc + TW'(alloc_valid[i]);
        end
        alloc_ready = !flush_valid && (count <= TW'(DEPTH - WIDTH));
    end

    // Squash mask: entries whose age from head exceeds the branch's age
    always_comb begin
        fdist = flush_tag - head_q;
        kill  = '0;
        for (int e = 0; e < DEPTH; e++) begin
            age_c[e] = DEPTH_LOG'(e) - head_q[DEPTH_LOG-1:0];
            kill[e]  = flush_valid && ({1'b0, age_c[e]} > fdist);
        end
    end

    // Commit group: leading run of valid+done entries from head
    always_comb begin
        chain    = 1'b1;
        elig     = 1'b0;
        cidx     = '0;
        n_commit = '0;
        cm_valid = '0;
        cm_rd    = '0;
        cm_data  = '0;
        cm_store = '0;
        cm_tag   = '0;
`ifdef REORDER_QUEUE_STORE_SERIAL_EN
        store_seen = 1'b0;
`endif
        for (int i = 0; i < WIDTH; i++) begin
            cm_tag[i]   = head_q + TW'(i);
            cidx        = cm_tag[i][DEPTH_LOG-1:0];
            cm_rd[i]    = rd_q[cidx];
            cm_data[i]  = data_q[cidx];
            cm_store[i] = store_q[cidx];
            // Never retire past a branch that is being squashed this cycle
            elig = valid_q[cidx] && done_q[cidx] && !(flush_valid && (TW'(i) > fdist));
`ifdef REORDER_QUEUE_STORE_SERIAL_EN
            elig = elig && !(store_q[cidx] && store_seen);
`endif
            chain       = chain && elig;
            cm_valid[i] = chain;
            n_commit    = n_commit + TW'(chain);
`ifdef REORDER_QUEUE_STORE_SERIAL_EN
            store_seen = store_seen || (chain && store_q[cidx]);
`endif
        end
    end

    // Entry state: later updates in this block take priority (commit/squash clear last)
    always_ff @(posedge clk) begin
        if (!reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            valid_q <= '0;
            done_q  <= '0;
            store_q <= '0;
        end else begin
            if (alloc_ready) begin
                for (int i = 0; i < WIDTH; i++) begin
                    if (alloc_valid[i]) begin
                        valid_q[alloc_tag[i][DEPTH_LOG-1:0]] <= 1'b1;
                        done_q[alloc_tag[i][DEPTH_LOG-1:0]]  <= 1'b0;
                        store_q[alloc_tag[i][DEPTH_LOG-1:0]] <= alloc_store[i];
                        rd_q[alloc_tag[i][DEPTH_LOG-1:0]]    <= alloc_rd[i];
                    end
                end
            end
            for (int i = 0; i < WIDTH; i++) begin
                if (wb_valid[i] && valid_q[wb_tag[i][DEPTH_LOG-1:0]]) begin
                    done_q[wb_tag[i][DEPTH_LOG-1:0]] <= 1'b1;
                    data_q[wb_tag[i][DEPTH_LOG-1:0]] <= wb_data[i];
                end
            end
            for (int i = 0; i < WIDTH; i++) begin
                if (cm_valid[i]) begin
                    valid_q[cm_tag[i][DEPTH_LOG-1:0]] <= 1'b0;
                    done_q[cm_tag[i][DEPTH_LOG-1:0]]  <= 1'b0;
                end
            end
            for (int e = 0; e < DEPTH; e++) begin
                if (kill[e]) begin
                    valid_q[e] <= 1'b0;
                    done_q[e]  <= 1'b0;
                end
            end
            if (flush_valid) begin
                tail_q <= flush_tag + TW'(1);
            end else if (alloc_ready) begin
                tail_q <= tail_q + n_alloc;
            end
            head_q <= head_q + n_commit;
        end
    end

endmodule

// File: tb/tb_reorder_queue.sv
// Scoreboard bench for reorder_queue: a program-order queue model predicts every cycle's
// outputs, a negedge monitor compares them. Directed scenarios followed by random traffic.
module tb_reorder_queue;

    localparam int unsigned W     = 2;
    localparam int unsigned DEPTH = 16;
    localparam int unsigned DL    = 4;
    localparam int unsigned DW    = 32;
    localparam int unsigned TW    = DL + 1;
    localparam int          NTAG  = 2 * DEPTH;

    logic                     clk = 1'b0;
    logic                     reset;
    logic [W-1:0]             alloc_valid;
    logic [W-1:0][4:0]        alloc_rd;
    logic [W-1:0]             alloc_store;
    logic                     alloc_ready;
    logic [W-1:0][TW-1:0]     alloc_tag;
    logic [W-1:0]             wb_valid;
    logic [W-1:0][TW-1:0]     wb_tag;
    logic [W-1:0][DW-1:0]     wb_data;
    logic                     flush_valid;
    logic [TW-1:0]            flush_tag;
    logic [W-1:0]             cm_valid;
    logic [W-1:0][4:0]        cm_rd;
    logic [W-1:0][DW-1:0]     cm_data;
    logic [W-1:0]             cm_store;
    logic [W-1:0][TW-1:0]     cm_tag;
    logic [TW-1:0]            count;

    reorder_queue #(.WIDTH(W), .DEPTH(DEPTH), .DEPTH_LOG(DL), .DATA_W(DW)) dut (
        .clk(clk), .reset(reset),
        .alloc_valid(alloc_valid), .alloc_rd(alloc_rd), .alloc_store(alloc_store),
        .alloc_ready(alloc_ready), .alloc_tag(alloc_tag),
        .wb_valid(wb_valid), .wb_tag(wb_tag), .wb_data(wb_data),
        .flush_valid(flush_valid), .flush_tag(flush_tag),
        .cm_valid(cm_valid), .cm_rd(cm_rd), .cm_data(cm_data), .cm_store(cm_store),
        .cm_tag(cm_tag), .count(count)
    );

    always #5 clk = ~clk;

    typedef struct {
        int           tag;
        logic [4:0]   rd;
        logic         st;
        logic         done;
        logic [DW-1:0] data;
    } ent_t;

    typedef struct packed {
        logic [W-1:0]          cmv;
        logic [W-1:0][TW-1:0]  tag;
        logic [W-1:0][4:0]     rd;
        logic [W-1:0][DW-1:0]  data;
        logic [W-1:0]          st;
        logic [TW-1:0]         cnt;
        logic                  rdy;
        logic [W-1:0][TW-1:0]  atag;
    } exp_t;

    ent_t rob[$];
    exp_t exp_q[$];
    int   m_tail = 0;
    int   vectors = 0;
    int   miscompares = 0;

    function automatic void cmp(string name, logic [63:0] got, logic [63:0] want);
        vectors++;
        if (got !== want) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, got, want);
        end
    endfunction

    task automatic clear_inputs();
        alloc_valid = '0; alloc_rd = '0; alloc_store = '0;
        wb_valid = '0; wb_tag = '0; wb_data = '0;
        flush_valid = 1'b0; flush_tag = '0;
    endtask

    // Predict this cycle's outputs, then advance the model across the coming edge
    task automatic issue();
        exp_t e;
        int   fpos;
        int   n;
        int   ns;
        e    = '0;
        fpos = NTAG;
        if (flush_valid)
            for (int j = 0; j < rob.size(); j++)
                if (rob[j].tag == int'(flush_tag)) fpos = j;
        e.cnt = TW'(rob.size());
        e.rdy = !flush_valid && (rob.size() <= int'(DEPTH - W));
        for (int i = 0; i < int'(W); i++) e.atag[i] = TW'((m_tail + i) % NTAG);
        n  = 0;
        ns = 0;
        for (int j = 0; j < int'(W) && j < rob.size(); j++) begin
            if (!rob[j].done || j > fpos) break;
`ifdef REORDER_QUEUE_STORE_SERIAL_EN
            if (rob[j].st && ns > 0) break;
`endif
            e.cmv[j]  = 1'b1;
            e.tag[j]  = TW'(rob[j].tag);
            e.rd[j]   = rob[j].rd;
            e.data[j] = rob[j].data;
            e.st[j]   = rob[j].st;
            ns += int'(rob[j].st);
            n++;
        end
        exp_q.push_back(e);
        for (int i = 0; i < int'(W); i++)
            if (wb_valid[i])
                for (int j = 0; j < rob.size(); j++)
                    if (rob[j].tag == int'(wb_tag[i]) && j <= fpos) begin
                        rob[j].done = 1'b1;
                        rob[j].data = wb_data[i];
                    end
        if (flush_valid)
            while (rob.size() > fpos + 1) void'(rob.pop_back());
        repeat (n) void'(rob.pop_front());
        if (flush_valid) begin
            m_tail = (int'(flush_tag) + 1) % NTAG;
        end else if (e.rdy) begin
            for (int i = 0; i < int'(W); i++)
                if (alloc_valid[i]) begin
                    rob.push_back('{m_tail, alloc_rd[i], alloc_store[i], 1'b0, '0});
                    m_tail = (m_tail + 1) % NTAG;
                end
        end
        @(posedge clk);
        #1;
        clear_inputs();
    endtask

    task automatic do_reset();
        logic [W-1:0][TW-1:0] at0;
        clear_inputs();
        reset = 1'b0;
        rob.delete();
        m_tail = 0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        for (int i = 0; i < int'(W); i++) at0[i] = TW'(i);
        cmp("reset_count", 64'(count), 64'(0));
        cmp("reset_alloc_ready", 64'(alloc_ready), 64'(1));
        cmp("reset_cm_valid", 64'(cm_valid), 64'(0));
        cmp("reset_alloc_tag", 64'(alloc_tag), 64'(at0));
    endtask

    task automatic alloc_pair(logic [W-1:0] st);
        alloc_valid = '1;
        alloc_store = st;
        for (int i = 0; i < int'(W); i++) alloc_rd[i] = 5'($urandom);
        issue();
    endtask

    task automatic drain();
        int k;
        for (int c = 0; c < 200 && rob.size() > 0; c++) begin
            k = 0;
            for (int j = 0; j < rob.size(); j++)
                if (!rob[j].done && k < int'(W)) begin
                    wb_valid[k] = 1'b1;
                    wb_tag[k]   = TW'(rob[j].tag);
                    wb_data[k]  = $urandom;
                    k++;
                end
            issue();
        end
        cmp("drain_count", 64'(count), 64'(0));
    endtask

    task automatic rand_cycle(int p_flush);
        int na;
        int k;
        int pos;
        int cand[$];
        na = $urandom_range(0, W);
        for (int i = 0; i < int'(W); i++) begin
            alloc_valid[i] = (i < na);
            alloc_rd[i]    = 5'($urandom);
            alloc_store[i] = 1'($urandom);
        end
        for (int j = 0; j < rob.size(); j++)
            if (!rob[j].done) cand.push_back(j);
        for (int i = 0; i < int'(W); i++) begin
            if (cand.size() > 0 && $urandom_range(0, 99) < 60) begin
                k = $urandom_range(0, cand.size() - 1);
                wb_valid[i] = 1'b1;
                wb_tag[i]   = TW'(rob[cand[k]].tag);
                wb_data[i]  = $urandom;
                cand.delete(k);
            end else if (rob.size() < int'(DEPTH) && $urandom_range(0, 9) == 0) begin
                wb_valid[i] = 1'b1;
                wb_tag[i]   = TW'(m_tail);
                wb_data[i]  = $urandom;
            end
        end
        if (rob.size() > 0 && $urandom_range(0, 99) < p_flush) begin
            pos         = $urandom_range(0, rob.size() - 1);
            flush_valid = 1'b1;
            flush_tag   = TW'(rob[pos].tag);
        end
        issue();
    endtask

    // Monitor: compare every predicted cycle against the DUT mid-cycle
    always @(negedge clk) begin
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            cmp("count", 64'(count), 64'(e.cnt));
            cmp("alloc_ready", 64'(alloc_ready), 64'(e.rdy));
            cmp("alloc_tag", 64'(alloc_tag), 64'(e.atag));
            cmp("cm_valid", 64'(cm_valid), 64'(e.cmv));
            for (int i = 0; i < int'(W); i++)
                if (e.cmv[i]) begin
                    cmp("cm_tag", 64'(cm_tag[i]), 64'(e.tag[i]));
                    cmp("cm_rd", 64'(cm_rd[i]), 64'(e.rd[i]));
                    cmp("cm_data", 64'(cm_data[i]), 64'(e.data[i]));
                    cmp("cm_store", 64'(cm_store[i]), 64'(e.st[i]));
                end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        do_reset();
        issue();

        // Out-of-order writeback: tags 3,1 then 0, then 2
        alloc_pair('0);
        alloc_pair('0);
        wb_valid = '1; wb_tag[0] = 5'd3; wb_tag[1] = 5'd1; wb_data = {32'($urandom), 32'($urandom)};
        issue();
        wb_valid = 2'b01; wb_tag[0] = 5'd0; wb_data[0] = $urandom;
        issue();
        cmp("ooo_cm_valid_a", 64'(cm_valid), 64'(2'b11));
        cmp("ooo_cm_tag0_a", 64'(cm_tag[0]), 64'(0));
        cmp("ooo_cm_tag1_a", 64'(cm_tag[1]), 64'(1));
        wb_valid = 2'b01; wb_tag[0] = 5'd2; wb_data[0] = $urandom;
        issue();
        cmp("ooo_cm_valid_b", 64'(cm_valid), 64'(2'b11));
        cmp("ooo_cm_tag0_b", 64'(cm_tag[0]), 64'(2));
        cmp("ooo_cm_tag1_b", 64'(cm_tag[1]), 64'(3));
        issue();
        cmp("ooo_empty", 64'(count), 64'(0));

        // Fill to full, then a stalled request is ignored
        for (int c = 0; c < 8; c++) alloc_pair(2'($urandom));
        cmp("full_count", 64'(count), 64'(16));
        cmp("full_ready", 64'(alloc_ready), 64'(0));
        alloc_pair('0);
        cmp("full_count_hold", 64'(count), 64'(16));
        drain();

        // Flush at tag 2 with a same-cycle writeback to squashed tag 4
        do_reset();
        for (int c = 0; c < 3; c++) alloc_pair('0);
        flush_valid = 1'b1; flush_tag = 5'd2;
        wb_valid = 2'b01; wb_tag[0] = 5'd4; wb_data[0] = $urandom;
        issue();
        cmp("flush_count", 64'(count), 64'(3));
        cmp("flush_alloc_tag", 64'(alloc_tag[0]), 64'(3));
        wb_valid = 2'b01; wb_tag[0] = 5'd4; wb_data[0] = $urandom;
        issue();
        cmp("flush_wb_dropped", 64'(count), 64'(3));
        alloc_pair('0);
        drain();

        // Two done stores at the head
        do_reset();
        alloc_pair(2'b11);
        wb_valid = '1; wb_tag[0] = 5'd0; wb_tag[1] = 5'd1; wb_data = {32'($urandom), 32'($urandom)};
        issue();
`ifdef REORDER_QUEUE_STORE_SERIAL_EN
        cmp("store_serial_c1", 64'(cm_valid), 64'(2'b01));
        issue();
        cmp("store_serial_c2", 64'(cm_valid), 64'(2'b01));
        cmp("store_serial_tag", 64'(cm_tag[0]), 64'(1));
`else
        cmp("store_both_c1", 64'(cm_valid), 64'(2'b11));
`endif
        drain();

        // Random traffic with wrap, flushes and invalid-tag writebacks
        for (int c = 0; c < 3000; c++) rand_cycle(4);
        drain();

        @(negedge clk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
